yarvi_trace_ctrl: RTL and testbench
===================================

# yarvi_trace_ctrl

Retire-trace capture controller for the yarvi core. It sits on the core's retire/write-back stream (the same valid/prv/pc/insn/wb_rd/wb_val signals the trace printer consumes) and sequences a trigger-armed capture window. Captured instructions are buffered in a small FIFO and drained to a downstream consumer (printer, UART packer, debug port) over a valid/ready handshake. The core is never stalled; overflow is counted rather than back-pressured.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of 2 and at least 2.
- `CNT_W`, 16: width of the capture-length and drop counters.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `retire_valid`  in  1  an instruction retires this cycle.
- `retire_prv`  in  2  privilege level at retire.
- `retire_pc`  in  `VMSB+1  pc of the retiring instruction.
- `retire_insn`  in  32  instruction word.
- `retire_rd`  in  5  write-back register; 0 means no write.
- `retire_val`  in  `VMSB+1  write-back value.
- `cfg_arm`  in  1  one-cycle pulse: flush the FIFO, latch the trigger PC and length, enter ARMED.
- `cfg_stop`  in  1  one-cycle pulse: end capture, enter DONE.
- `cfg_trig_pc`  in  `VMSB+1  trigger PC; sampled on `cfg_arm`.
- `cfg_len`  in  CNT_W  number of entries to capture; 0 means unbounded. Sampled on `cfg_arm`.
- `trace_valid`  out  1  FIFO head valid.
- `trace_ready`  in  1  consumer accepts the head.
- `trace_prv`, `trace_pc`, `trace_insn`, `trace_rd`, `trace_val`  out  same widths as retire_*  FIFO head fields.
- `state`  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
- `drop_cnt`  out  CNT_W  entries lost to a full FIFO; saturates at all-ones.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- FSM transitions:
  - IDLE: on `cfg_arm`, go to ARMED.
  - ARMED: on `retire_valid` with `retire_pc == trig_pc`, go to CAPTURE. The triggering instruction is captured as entry 1.
  - CAPTURE: every `retire_valid` captures one entry. When `cfg_len != 0`, `remaining` (loaded with `cfg_len`) decrements on each capture attempt. The capture that takes `remaining` to 0 moves the FSM to DONE.
  - DONE: holds. `cfg_arm` moves to ARMED.
- `cfg_arm` is accepted in every state and takes priority over everything except `reset`. It empties the FIFO, clears `drop_cnt` and `overflow`, and discards any entry presented that same cycle.
- `cfg_stop` in ARMED or CAPTURE moves to DONE and suppresses any capture that cycle. In IDLE or DONE it is ignored.
- Priority: `reset` > `cfg_arm` > `cfg_stop` > trigger/capture.
- A capture attempt is a push into the FIFO.
  - If the FIFO is full and no pop occurs the same cycle, the entry is dropped: `drop_cnt` increments (saturating) and `overflow` is set.
  - A dropped entry still counts against `remaining`, so the window length is measured in retired instructions, not stored entries.
- Pop: `trace_valid && trace_ready`. Pops proceed in every state, including IDLE and DONE, until the FIFO is empty.
- Simultaneous push and pop:
  - Allowed at any occupancy. Occupancy is unchanged.
  - When full, the pop frees the slot and the push is accepted, not dropped.
  - When empty, the push is accepted; nothing is popped because `trace_valid` is 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter of log2(DEPTH)+1 bits, range 0..DEPTH.
- Head fields are don't-care while `trace_valid` = 0. They are stable while `trace_valid` = 1 and `trace_ready` = 0.
- `cfg_len` = 1: the trigger instruction alone is captured, then DONE.

## Timing
- Reset values: `state` = IDLE, FIFO empty, `trace_valid` = 0, `drop_cnt` = 0, `overflow` = 0, `remaining` = 0, `trig_pc` = 0.
- Capture latency is 1 cycle: an entry pushed at edge N drives `trace_valid` = 1 in the cycle after edge N, provided the FIFO was empty.
- `state` is registered. The trigger cycle's edge sets `state` = CAPTURE. The final capture's edge sets `state` = DONE.
- `trace_valid` is derived from the registered occupancy, with no combinational path from `retire_*`. `trace_ready` affects only the next-state logic.
- Throughput: one push and one pop per cycle, sustained.
- `reset` asserted mid-capture: the FIFO is emptied and the FSM returns to IDLE on that edge. The pending head is lost.

## Test plan
- Trigger and length: arm with `trig_pc` = 0x100, `cfg_len` = 3. Retire pcs 0xF8, 0xFC, 0x100, 0x104, 0x108, 0x10C with `trace_ready` = 1. Required: exactly 0x100, 0x104 and 0x108 are drained in order; `state` = DONE after the 0x108 edge; `drop_cnt` = 0.
- Overflow: `DEPTH` = 16, `cfg_len` = 0, `trace_ready` = 0, 20 consecutive retires after the trigger. Required: 16 entries are held; `drop_cnt` = 4; `overflow` = 1; the drained order is the first 16 captured, with no corruption.
- Full with simultaneous push and pop: FIFO full, `trace_ready` = 1, retiring every cycle for 10 cycles. Required: no drops; occupancy stays at 16.
- Stop and re-arm: `cfg_stop` during CAPTURE while 5 entries are buffered. Required: FSM goes to DONE and the 5 entries still drain. Then `cfg_arm` with 2 entries still buffered. Required: FIFO empties the next cycle, `drop_cnt` = 0, `state` = ARMED.
- Priority: `cfg_arm` and `cfg_stop` in the same cycle. Required: `state` = ARMED. A trigger-PC retire in the same cycle as `cfg_stop`. Required: DONE with nothing captured.
- Reset mid-operation: assert `reset` for 1 cycle with 7 entries buffered in CAPTURE. Required: `trace_valid` = 0, `state` = IDLE, and all counters are 0 the cycle after.

Source files
------------

// File: rtl/yarvi_trace_ctrl.sv
// Retire-trace capture controller: trigger-armed capture window feeding
// a small FIFO that drains over valid/ready. The core is never stalled.
module yarvi_trace_ctrl #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16,
   parameter int VMSB  = 31
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             retire_valid,
   input  logic [1:0]       retire_prv,
   input  logic [VMSB:0]    retire_pc,
   input  logic [31:0]      retire_insn,
   input  logic [4:0]       retire_rd,
   input  logic [VMSB:0]    retire_val,
   input  logic             cfg_arm,
   input  logic             cfg_stop,
   input  logic [VMSB:0]    cfg_trig_pc,
   input  logic [CNT_W-1:0] cfg_len,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [1:0]       trace_prv,
   output logic [VMSB:0]    trace_pc,
   output logic [31:0]      trace_insn,
   output logic [4:0]       trace_rd,
   output logic [VMSB:0]    trace_val,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   typedef struct packed {
      logic [1:0]    prv;
      logic [VMSB:0] pc;
      logic [31:0]   insn;
      logic [4:0]    rd;
      logic [VMSB:0] val;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           wr_entry;
   entry_t           head;

   logic [1:0]       state_q, state_d;
   logic [VMSB:0]    trig_pc_q, trig_pc_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   logic             full;
   logic             pop;
   logic             stop_ok;
   logic             hit;
   logic             attempt;
   logic             push;
   logic             drop;

   assign trace_valid = (count_q != '0);
   assign full        = (count_q == FULL_CNT);
   assign pop         = trace_valid && trace_ready;

   assign stop_ok = cfg_stop &&
                    (state_q == S_ARMED || state_q == S_CAPTURE);

   assign hit = retire_valid &&
                ((state_q == S_ARMED && retire_pc == trig_pc_q) ||
                 state_q == S_CAPTURE);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign attempt = !cfg_arm && !stop_ok && hit;
   assign push    = attempt && (!full || pop);
   assign drop    = attempt && full && !pop;

   assign wr_entry.prv  = retire_prv;
   assign wr_entry.pc   = retire_pc;
   assign wr_entry.insn = retire_insn;
   assign wr_entry.rd   = retire_rd;
   assign wr_entry.val  = retire_val;

   always_comb begin
      state_d     = state_q;
      trig_pc_d   = trig_pc_q;
      remaining_d = remaining_q;
      drop_cnt_d  = drop_cnt_q;
      overflow_d  = overflow_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (cfg_arm) begin
         state_d     = S_ARMED;
         trig_pc_d   = cfg_trig_pc;
         remaining_d = cfg_len;
         drop_cnt_d  = '0;
         overflow_d  = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (push && !pop) count_d = count_q + 1'b1;
         if (!push && pop) count_d = count_q - 1'b1;
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
         end
         // remaining == 0 while capturing means an unbounded window.
         if (stop_ok) begin
            state_d = S_DONE;
         end else if (attempt) begin
            state_d = S_CAPTURE;
            if (remaining_q != '0) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         trig_pc_q   <= '0;
         remaining_q <= '0;
         drop_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         trig_pc_q   <= trig_pc_d;
         remaining_q <= remaining_d;
         drop_cnt_q  <= drop_cnt_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign head       = mem_q[rd_ptr_q];
   assign trace_prv  = head.prv;
   assign trace_pc   = head.pc;
   assign trace_insn = head.insn;
   assign trace_rd   = head.rd;
   assign trace_val  = head.val;

   assign state    = state_q;
   assign drop_cnt = drop_cnt_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_yarvi_trace_ctrl.sv
// Bench for yarvi_trace_ctrl: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_yarvi_trace_ctrl;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int VMSB  = 31;

   logic             clock = 1'b0;
   logic             reset;
   logic             retire_valid;
   logic [1:0]       retire_prv;
   logic [VMSB:0]    retire_pc;
   logic [31:0]      retire_insn;
   logic [4:0]       retire_rd;
   logic [VMSB:0]    retire_val;
   logic             cfg_arm;
   logic             cfg_stop;
   logic [VMSB:0]    cfg_trig_pc;
   logic [CNT_W-1:0] cfg_len;
   logic             trace_valid;
   logic             trace_ready;
   logic [1:0]       trace_prv;
   logic [VMSB:0]    trace_pc;
   logic [31:0]      trace_insn;
   logic [4:0]       trace_rd;
   logic [VMSB:0]    trace_val;
   logic [1:0]       state;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow;

   always #5 clock = ~clock;

   yarvi_trace_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .VMSB(VMSB)) dut (
      .clock(clock), .reset(reset),
      .retire_valid(retire_valid), .retire_prv(retire_prv),
      .retire_pc(retire_pc), .retire_insn(retire_insn),
      .retire_rd(retire_rd), .retire_val(retire_val),
      .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
      .cfg_trig_pc(cfg_trig_pc), .cfg_len(cfg_len),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_prv(trace_prv), .trace_pc(trace_pc),
      .trace_insn(trace_insn), .trace_rd(trace_rd),
      .trace_val(trace_val), .state(state),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  prv;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [31:0] val;
   } ent_t;

   // Reference model: a queue of captured entries plus window bookkeeping.
   ent_t        mq[$];
   int          m_state = 0;
   logic [31:0] m_trig = 0;
   int          m_rem = 0;
   int          m_drops = 0;
   bit          m_ovf = 0;

   logic [31:0] popped[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input ent_t e, input bit rv, input bit arm,
                             input bit stop, input bit rdy,
                             input logic [31:0] trig, input int len,
                             input bit rst);
      bit cap;
      cap = 0;
      if (rst) begin
         mq.delete();
         m_state = 0; m_trig = 0; m_rem = 0; m_drops = 0; m_ovf = 0;
      end else if (arm) begin
         mq.delete();
         m_state = 1; m_trig = trig; m_rem = len; m_drops = 0; m_ovf = 0;
      end else begin
         if (rdy && mq.size() > 0) void'(mq.pop_front());
         if (stop && (m_state == 1 || m_state == 2)) begin
            m_state = 3;
         end else if (rv && ((m_state == 1 && e.pc == m_trig) ||
                             m_state == 2)) begin
            cap = 1;
            m_state = 2;
            if (m_rem > 0) begin
               m_rem--;
               if (m_rem == 0) m_state = 3;
            end
         end
         if (cap) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else begin
               m_ovf = 1;
               if (m_drops < 65535) m_drops++;
            end
         end
      end
   endtask

   task automatic check_model();
      chk("m_state", state, m_state);
      chk("m_valid", trace_valid, mq.size() != 0);
      chk("m_drop_cnt", drop_cnt, m_drops);
      chk("m_overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
         chk("m_head_pc", trace_pc, mq[0].pc);
         chk("m_head_prv", trace_prv, mq[0].prv);
         chk("m_head_insn", trace_insn, mq[0].insn);
         chk("m_head_rd", trace_rd, mq[0].rd);
         chk("m_head_val", trace_val, mq[0].val);
      end
   endtask

   task automatic cyc(input bit rv, input logic [31:0] pc, input bit arm,
                      input bit stop, input bit rdy,
                      input logic [31:0] trig, input logic [15:0] len,
                      input bit rst);
      ent_t e;
      e.prv  = 2'($urandom_range(0, 3));
      e.pc   = pc;
      e.insn = $urandom;
      e.rd   = 5'($urandom_range(0, 31));
      e.val  = $urandom;
      reset        = rst;
      retire_valid = rv;
      retire_prv   = e.prv;
      retire_pc    = e.pc;
      retire_insn  = e.insn;
      retire_rd    = e.rd;
      retire_val   = e.val;
      cfg_arm      = arm;
      cfg_stop     = stop;
      cfg_trig_pc  = trig;
      cfg_len      = len;
      trace_ready  = rdy;
      if (trace_valid && rdy && !rst) popped.push_back(trace_pc);
      model_step(e, rv, arm, stop, rdy, trig, int'(len), rst);
      @(posedge clock);
      #1;
      check_model();
   endtask

   task automatic step(input bit rv, input logic [31:0] pc, input bit rdy);
      cyc(rv, pc, 1'b0, 1'b0, rdy, 32'h0, 16'h0, 1'b0);
   endtask

   task automatic arm_cmd(input logic [31:0] trig, input logic [15:0] len,
                          input bit rdy);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, rdy, trig, len, 1'b0);
   endtask

   typedef struct {
      bit          rv;
      logic [31:0] pc;
      bit          arm;
      bit          stop;
      bit          rdy;
      logic [31:0] trig;
      logic [15:0] len;
      logic [1:0]  e_state;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n;
      int bias;
      logic [31:0] exp_pc;

      tbl[0] = '{0, 32'h000, 1, 0, 1, 32'h100, 16'd3, 2'd1, 0, 32'h000};
      tbl[1] = '{1, 32'h0F8, 0, 0, 1, 32'h000, 16'd0, 2'd1, 0, 32'h000};
      tbl[2] = '{1, 32'h0FC, 0, 0, 1, 32'h000, 16'd0, 2'd1, 0, 32'h000};
      tbl[3] = '{1, 32'h100, 0, 0, 1, 32'h000, 16'd0, 2'd2, 1, 32'h100};
      tbl[4] = '{1, 32'h104, 0, 0, 1, 32'h000, 16'd0, 2'd2, 1, 32'h104};
      tbl[5] = '{1, 32'h108, 0, 0, 1, 32'h000, 16'd0, 2'd3, 1, 32'h108};
      tbl[6] = '{1, 32'h10C, 0, 0, 1, 32'h000, 16'd0, 2'd3, 0, 32'h000};
      tbl[7] = '{0, 32'h000, 0, 0, 1, 32'h000, 16'd0, 2'd3, 0, 32'h000};
      tbl[8] = '{0, 32'h000, 1, 1, 1, 32'h100, 16'd3, 2'd1, 0, 32'h000};
      tbl[9] = '{1, 32'h100, 0, 1, 1, 32'h000, 16'd0, 2'd3, 0, 32'h000};

      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("reset_state", state, 0);
      chk("reset_valid", trace_valid, 0);
      chk("reset_drop", drop_cnt, 0);
      chk("reset_ovf", overflow, 0);

      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].rv, tbl[i].pc, tbl[i].arm, tbl[i].stop, tbl[i].rdy,
             tbl[i].trig, tbl[i].len, 1'b0);
         chk($sformatf("vec%0d_state", i), state, tbl[i].e_state);
         chk($sformatf("vec%0d_valid", i), trace_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d_drop", i), drop_cnt, 0);
         if (tbl[i].e_valid)
            chk($sformatf("vec%0d_pc", i), trace_pc, tbl[i].e_pc);
      end

      // Overflow: 20 captures into a 16-deep FIFO with no consumer.
      arm_cmd(32'h200, 16'd0, 0);
      for (int i = 0; i < 20; i++) step(1, 32'h200 + 32'(4 * i), 0);
      chk("ovf_drop_cnt", drop_cnt, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", trace_valid, 1);

      // Full FIFO with push and pop every cycle: nothing more is dropped.
      popped.delete();
      for (int i = 0; i < 10; i++) step(1, 32'h250 + 32'(4 * i), 1);
      chk("full_pp_drop", drop_cnt, 4);
      chk("full_pp_pops", popped.size(), 10);
      for (int i = 0; i < popped.size(); i++)
         chk($sformatf("full_pp_pop%0d", i), popped[i], 32'h200 + 32'(4 * i));
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      chk("full_pp_done", state, 3);
      popped.delete();
      for (int i = 0; i < 40 && trace_valid; i++) step(0, 0, 1);
      chk("full_pp_occ", popped.size(), 16);
      for (int i = 0; i < popped.size(); i++) begin
         exp_pc = (i < 6) ? 32'h200 + 32'(4 * (10 + i))
                          : 32'h250 + 32'(4 * (i - 6));
         chk($sformatf("drain%0d", i), popped[i], exp_pc);
      end
      chk("drain_empty", trace_valid, 0);

      // Stop with 5 buffered, drain 3, re-arm with 2 still queued.
      arm_cmd(32'h300, 16'd0, 0);
      for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(4 * i), 0);
      cyc(1, 32'h314, 0, 1, 0, 0, 0, 0);
      chk("stop_state", state, 3);
      popped.delete();
      for (int i = 0; i < 3; i++) step(1, 32'h318, 1);
      chk("stop_drained", popped.size(), 3);
      for (int i = 0; i < popped.size(); i++)
         chk($sformatf("stop_pop%0d", i), popped[i], 32'h300 + 32'(4 * i));
      chk("stop_left", trace_valid, 1);
      arm_cmd(32'h300, 16'd0, 0);
      chk("rearm_valid", trace_valid, 0);
      chk("rearm_drop", drop_cnt, 0);
      chk("rearm_state", state, 1);

      // Length 1: only the trigger instruction is captured.
      arm_cmd(32'h500, 16'd1, 0);
      step(1, 32'h4FC, 0);
      step(1, 32'h500, 0);
      chk("len1_state", state, 3);
      chk("len1_pc", trace_pc, 32'h500);
      step(1, 32'h504, 0);
      popped.delete();
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      chk("len1_count", popped.size(), 1);

      // Reset mid-capture with 7 buffered and drops recorded.
      arm_cmd(32'h400, 16'd0, 0);
      for (int i = 0; i < 19; i++) step(1, 32'h400 + 32'(4 * i), 0);
      for (int i = 0; i < 9; i++) step(0, 0, 1);
      chk("prerst_drop", drop_cnt, 3);
      chk("prerst_state", state, 2);
      cyc(1, 32'h500, 0, 0, 0, 0, 0, 1);
      chk("rst_valid", trace_valid, 0);
      chk("rst_state", state, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", overflow, 0);

      // Random traffic with varying consumer speed.
      bias = 50;
      for (int i = 0; i < 4000; i++) begin
         int r;
         bit rv;
         bit rdy;
         logic [31:0] pc;
         logic [31:0] trig;
         logic [15:0] len;
         if (i % 500 == 0) begin
            n = $urandom_range(0, 2);
            bias = (n == 0) ? 10 : (n == 1) ? 50 : 95;
         end
         r    = $urandom_range(0, 199);
         rv   = ($urandom_range(0, 3) != 0);
         rdy  = ($urandom_range(0, 99) < bias);
         pc   = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         trig = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         len  = ($urandom_range(0, 3) == 0) ? 16'd0
                                             : 16'($urandom_range(1, 24));
         cyc(rv, pc, r < 4, r >= 4 && r < 7, rdy, trig, len, r == 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
